// File: rtl/lock_pkg.sv
// lock_pkg: shared constants and enums for the locked-key table and its snoopers.
// Rev 1.0
`default_nettype none

package lock_pkg;

   // Free slots hold this key so snoopers can compare without valid qualification.
   localparam logic [31:0] INVALID_KEY = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      ERR_NONE    = 2'd0,
      ERR_DUP     = 2'd1,
      ERR_FULL    = 2'd2,
      ERR_ILLEGAL = 2'd3
   } lock_err_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SEARCH = 2'd1,
      ST_RESP   = 2'd2
   } lock_state_e;

endpackage

`default_nettype wire

// File: rtl/lock_free_finder.sv
// lock_free_finder: lowest-index clear bit of the slot-valid vector.
// Rev 1.0
`default_nettype none

module lock_free_finder #(
   parameter int N = 4,
   parameter int W = $clog2(N)
) (
   input  logic [N-1:0] valid,
   output logic         found,
   output logic [W-1:0] idx
);

   // Scan from the top so the last hit written is the lowest free index.
   always_comb begin
      found = 1'b0;
      idx   = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (!valid[i]) begin
            found = 1'b1;
            idx   = W'(i);
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/key_lock_table.sv
// key_lock_table: allocates/frees slots of the locked-key table over a ready/valid lock port.
// Rev 1.0
`default_nettype none

module key_lock_table
   import lock_pkg::*;
#(
   parameter int MAX_LOCK_KEYS = 4,
   localparam int SLOT_W = $clog2(MAX_LOCK_KEYS),
   localparam int CNT_W  = $clog2(MAX_LOCK_KEYS + 1)
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        lock_req,
   input  logic [31:0]                 lock_key,
   output logic                        lock_ready,
   output logic                        lock_done,
   output logic                        lock_ok,
   output logic [1:0]                  lock_err,
   output logic [SLOT_W-1:0]           lock_slot,
   input  logic                        unlock_req,
   input  logic [SLOT_W-1:0]           unlock_slot,
   output logic [32*MAX_LOCK_KEYS-1:0] locked_key,
   output logic [MAX_LOCK_KEYS-1:0]    locked_valid,
   output logic [CNT_W-1:0]            lock_count,
   output logic                        full
);

   lock_state_e              state;
   logic [31:0]              key_q;
   logic                     free_found;
   logic [SLOT_W-1:0]        free_idx;
   logic                     dup;
   logic                     grant;
   logic                     do_grant;
   lock_err_e                err_d;
   logic [MAX_LOCK_KEYS-1:0] unlock_hit;
   logic                     unlock_eff;
   logic [CNT_W-1:0]         count_next;

   lock_free_finder #(
      .N (MAX_LOCK_KEYS),
      .W (SLOT_W)
   ) u_free_finder (
      .valid (locked_valid),
      .found (free_found),
      .idx   (free_idx)
   );

   always_comb begin
      dup        = 1'b0;
      unlock_hit = '0;
      for (int i = 0; i < MAX_LOCK_KEYS; i++) begin
         if (locked_valid[i] && locked_key[i*32 +: 32] == key_q)
            dup = 1'b1;
         // Out-of-range and free-slot unlocks match no bit and fall away here.
         unlock_hit[i] = unlock_req && (unlock_slot == SLOT_W'(i)) && locked_valid[i];
      end
      unlock_eff = |unlock_hit;
   end

   always_comb begin
      err_d = ERR_NONE;
      grant = 1'b0;
      if (key_q == INVALID_KEY)
         err_d = ERR_ILLEGAL;
      else if (dup)
         err_d = ERR_DUP;
      else if (!free_found)
         err_d = ERR_FULL;
      else
         grant = 1'b1;
   end

   assign do_grant = (state == ST_SEARCH) && grant;

   always_comb begin
      count_next = lock_count;
      if (do_grant && !unlock_eff)
         count_next = lock_count + CNT_W'(1);
      else if (!do_grant && unlock_eff)
         count_next = lock_count - CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= ST_IDLE;
         key_q        <= INVALID_KEY;
         locked_key   <= {MAX_LOCK_KEYS{INVALID_KEY}};
         locked_valid <= '0;
         lock_count   <= '0;
         full         <= 1'b0;
         lock_ready   <= 1'b1;
         lock_done    <= 1'b0;
         lock_ok      <= 1'b0;
         lock_err     <= ERR_NONE;
         lock_slot    <= '0;
      end else begin
         // A grant only targets a free slot and an unlock only a valid one.
         for (int i = 0; i < MAX_LOCK_KEYS; i++) begin
            if (unlock_hit[i]) begin
               locked_valid[i]        <= 1'b0;
               locked_key[i*32 +: 32] <= INVALID_KEY;
            end else if (do_grant && free_idx == SLOT_W'(i)) begin
               locked_valid[i]        <= 1'b1;
               locked_key[i*32 +: 32] <= key_q;
            end
         end
         lock_count <= count_next;
         full       <= (count_next == CNT_W'(MAX_LOCK_KEYS));

         case (state)
            ST_IDLE: begin
               if (lock_req && lock_ready) begin
                  key_q      <= lock_key;
                  lock_ready <= 1'b0;
                  state      <= ST_SEARCH;
               end
            end
            ST_SEARCH: begin
               lock_done <= 1'b1;
               lock_ok   <= grant;
               lock_err  <= err_d;
               lock_slot <= grant ? free_idx : '0;
               state     <= ST_RESP;
            end
            ST_RESP: begin
               lock_done  <= 1'b0;
               lock_ok    <= 1'b0;
               lock_err   <= ERR_NONE;
               lock_slot  <= '0;
               lock_ready <= 1'b1;
               state      <= ST_IDLE;
            end
            default: begin
               lock_ready <= 1'b1;
               state      <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire
